// File: rtl/tmr_recovery_ctrl_pkg.sv
// Shared definitions for the TMR recovery controller: state encoding,
// core bit indices and small decode helpers.
package tmr_recovery_ctrl_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CORE_A = 0;
  localparam int unsigned CORE_B = 1;
  localparam int unsigned CORE_C = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIRM,
    ST_DRAIN,
    ST_COPY,
    ST_RESUME,
    ST_FATAL
  } state_e;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Golden core is the lowest-index core not flagged in the captured fault.
  function automatic logic [1:0] golden_idx(input logic [2:0] lf);
    if (!lf[CORE_A]) return 2'd0;
    else if (!lf[CORE_B]) return 2'd1;
    else return 2'd2;
  endfunction

endpackage

// File: rtl/tmr_recovery_ctrl_filter.sv
// Persistence filter for voter mismatch flags: tracks how long one single-core
// fault pattern has held and decodes multi-core faults.
module tmr_fault_filter
  import tmr_recovery_ctrl_pkg::*;
#(
  parameter int unsigned PERSIST = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] fault_vec,
  output logic       confirmed_single,
  output logic       multi_fault,
  output logic [2:0] stable_vec
);

  localparam logic [3:0] PERSIST_C = 4'(PERSIST);

  logic [3:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;

  assign multi_fault      = (popcount3(fault_vec) >= 2'd2);
  assign confirmed_single = (cnt_q == PERSIST_C) && (vec_q != '0);
  assign stable_vec       = vec_q;

  always_comb begin
    cnt_d = cnt_q;
    vec_d = vec_q;
    if (!enable || multi_fault || (fault_vec == '0)) begin
      cnt_d = '0;
      vec_d = '0;
    end else if ((fault_vec == vec_q) && (cnt_q != '0)) begin
      if (cnt_q < PERSIST_C) cnt_d = cnt_q + 4'd1;
    end else begin
      // New or different single-core pattern restarts the count.
      cnt_d = 4'd1;
      vec_d = fault_vec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      vec_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vec_q <= vec_d;
    end
  end

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// Recovery sequencer for the triplicated core: confirms a single-core fault,
// stalls all cores, copies x1..x31 from a golden core into the faulty one.
module tmr_recovery_ctrl
  import tmr_recovery_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned PERSIST  = 2,
  parameter int unsigned COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         fault_vec,
  output logic               core_stall,
  output logic [REG_AW-1:0]  rf_raddr,
  input  logic [31:0]        rf_rdata_a,
  input  logic [31:0]        rf_rdata_b,
  input  logic [31:0]        rf_rdata_c,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic [2:0]         rf_we,
  output logic               recover_busy,
  output logic               fatal,
  output logic [2:0]         last_fault,
  output logic [COUNT_W-1:0] fault_count
);

  localparam logic [REG_AW-1:0] LAST_ADDR = REG_AW'(NUM_REGS - 1);

  state_e               state_q, state_d;
  logic                 core_stall_q, core_stall_d;
  logic                 recover_busy_q, recover_busy_d;
  logic                 fatal_q, fatal_d;
  logic [2:0]           last_fault_q, last_fault_d;
  logic [COUNT_W-1:0]   fault_count_q, fault_count_d;
  logic [REG_AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]          rf_wdata_q, rf_wdata_d;
  logic [2:0]           rf_we_q, rf_we_d;

  logic                 filt_en;
  logic                 confirmed_single;
  logic                 multi_fault;
  logic [2:0]           stable_vec;
  logic [31:0]          golden_rdata;

  assign filt_en = (state_q == ST_IDLE) || (state_q == ST_CONFIRM);

  tmr_fault_filter #(
    .PERSIST(PERSIST)
  ) u_filter (
    .clk              (clk),
    .rst              (rst),
    .enable           (filt_en),
    .fault_vec        (fault_vec),
    .confirmed_single (confirmed_single),
    .multi_fault      (multi_fault),
    .stable_vec       (stable_vec)
  );

  always_comb begin
    unique case (golden_idx(last_fault_q))
      2'd0:    golden_rdata = rf_rdata_a;
      2'd1:    golden_rdata = rf_rdata_b;
      default: golden_rdata = rf_rdata_c;
    endcase
  end

  // Read runs one address ahead of the registered write; wraps to x0 on the last write.
  always_comb begin
    rf_raddr = '0;
    if (state_q == ST_DRAIN)     rf_raddr = REG_AW'(1);
    else if (state_q == ST_COPY) rf_raddr = rf_waddr_q + REG_AW'(1);
  end

  always_comb begin
    state_d       = state_q;
    last_fault_d  = last_fault_q;
    fault_count_d = fault_count_q;
    rf_waddr_d    = '0;
    rf_wdata_d    = '0;
    rf_we_d       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (multi_fault)            state_d = ST_FATAL;
        else if (fault_vec != '0)   state_d = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (multi_fault) begin
          state_d = ST_FATAL;
        end else if (confirmed_single) begin
          state_d      = ST_DRAIN;
          last_fault_d = stable_vec;
        end else if (fault_vec == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        state_d    = ST_COPY;
        rf_waddr_d = REG_AW'(1);
        rf_wdata_d = golden_rdata;
        rf_we_d    = last_fault_q;
      end
      ST_COPY: begin
        if (rf_waddr_q == LAST_ADDR) begin
          state_d = ST_RESUME;
          if (fault_count_q != '1) fault_count_d = fault_count_q + COUNT_W'(1);
        end else begin
          rf_waddr_d = rf_waddr_q + REG_AW'(1);
          rf_wdata_d = golden_rdata;
          rf_we_d    = last_fault_q;
        end
      end
      ST_RESUME: state_d = ST_IDLE;
      ST_FATAL:  state_d = ST_FATAL;
      default:   state_d = ST_IDLE;
    endcase
    core_stall_d   = state_d inside {ST_DRAIN, ST_COPY, ST_RESUME, ST_FATAL};
    recover_busy_d = state_d inside {ST_DRAIN, ST_COPY, ST_RESUME};
    fatal_d        = (state_d == ST_FATAL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      core_stall_q   <= 1'b0;
      recover_busy_q <= 1'b0;
      fatal_q        <= 1'b0;
      last_fault_q   <= '0;
      fault_count_q  <= '0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      rf_we_q        <= '0;
    end else begin
      state_q        <= state_d;
      core_stall_q   <= core_stall_d;
      recover_busy_q <= recover_busy_d;
      fatal_q        <= fatal_d;
      last_fault_q   <= last_fault_d;
      fault_count_q  <= fault_count_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      rf_we_q        <= rf_we_d;
    end
  end

  assign core_stall   = core_stall_q;
  assign recover_busy = recover_busy_q;
  assign fatal        = fatal_q;
  assign last_fault   = last_fault_q;
  assign fault_count  = fault_count_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign rf_we        = rf_we_q;

endmodule
